// File: rtl/tpu_defs.sv
`default_nettype none
// ============================================================================
// Module   : tpu_defs (package)
// Purpose  : Shared definitions for the 4x4 systolic MAC array and the
//            array_feeder that drives it. Holds element and accumulator
//            widths, the array dimension, the stream length and the feeder
//            state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package tpu_defs;

  localparam int DATA_WIDTH = 8;          // A/B element width, signed
  localparam int ACC_WIDTH  = 16;         // array accumulator width
  localparam int N          = 4;          // array dimension
  localparam int STREAM_LEN = 3 * N - 2;  // cycles with we high
  localparam int CNT_WIDTH  = 4;          // holds 0..STREAM_LEN

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/array_feeder_lane.sv
`default_nettype none
// ============================================================================
// Module   : feeder_lane
// Purpose  : Selects the diagonally skewed element for one array lane.
//            Element k of the slice is presented when t == LANE + k;
//            every other count (and any cycle with en low) yields 0.
// Ports    : slice - N elements, element k in bits [DW*k +: DW]
//            t     - stream counter
//            en    - high only while streaming
//            elem  - selected element or 0
// Revision : 1.0 - initial release
// ============================================================================
module feeder_lane #(
  parameter int DATA_WIDTH = tpu_defs::DATA_WIDTH,
  parameter int N          = tpu_defs::N,
  parameter int CNT_WIDTH  = tpu_defs::CNT_WIDTH,
  parameter int LANE       = 0
) (
  input  logic [DATA_WIDTH*N-1:0] slice,
  input  logic [CNT_WIDTH-1:0]    t,
  input  logic                    en,
  output logic [DATA_WIDTH-1:0]   elem
);

  // Compare t against LANE+k rather than computing t-LANE, so counts below
  // LANE never wrap into a valid index.
  always_comb begin
    elem = '0;
    for (int k = 0; k < N; k++) begin
      if (en && (int'(t) == LANE + k)) begin
        elem = slice[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/array_feeder.sv
`default_nettype none
// ============================================================================
// Module   : array_feeder
// Purpose  : Input sequencer for the 4x4 systolic MAC array. Buffers one
//            activation matrix A and one weight matrix B (written a row at a
//            time) and, on start, streams them into a_in/b_in with the
//            diagonal skew the array needs, zero padded, holding we high for
//            STREAM_LEN cycles.
// Ports    : clk, rst_n         - clock, async active-low reset
//            ld_valid/ld_ready  - row load handshake (ready only in IDLE)
//            ld_sel, ld_row     - target matrix (0=A, 1=B) and row index
//            ld_data            - row elements, element j in [8j+7:8j]
//            start              - begin streaming (sampled in IDLE only)
//            busy, done         - not-IDLE flag, one-cycle completion pulse
//            a_in, b_in, we     - array data/enable inputs
// Revision : 1.0 - initial release
// ============================================================================
module array_feeder #(
  parameter int DATA_WIDTH = tpu_defs::DATA_WIDTH,
  parameter int N          = tpu_defs::N
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic                    ld_sel,
  input  logic [1:0]              ld_row,
  input  logic [DATA_WIDTH*N-1:0] ld_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH*N-1:0] a_in,
  output logic [DATA_WIDTH*N-1:0] b_in,
  output logic                    we
);

  import tpu_defs::*;

  localparam logic [CNT_WIDTH-1:0] c_t_last = CNT_WIDTH'(STREAM_LEN - 1);

  // Row-major buffers: r_a[i] holds A row i, r_b[k] holds B row k.
  logic [DATA_WIDTH*N-1:0] r_a [N];
  logic [DATA_WIDTH*N-1:0] r_b [N];

  state_t                  r_state;
  logic [CNT_WIDTH-1:0]    r_t;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_ld_ready;
  logic                    r_we;

  logic                    w_ld_fire;

  assign w_ld_fire = ld_valid && r_ld_ready;

  // --------------------------------------------------------------------------
  // Matrix buffers. Writes are only possible in IDLE because ld_ready is low
  // everywhere else; a write coinciding with start lands before t=0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else if (w_ld_fire) begin
      if (ld_sel) begin
        r_b[ld_row] <= ld_data;
      end else begin
        r_a[ld_row] <= ld_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM. Status outputs are registered alongside the state so they
  // change on the same edge as the state they describe.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_t        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ld_ready <= 1'b1;
      r_we       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= STREAM;
            r_t        <= '0;
            r_busy     <= 1'b1;
            r_ld_ready <= 1'b0;
            r_we       <= 1'b1;
          end
        end
        STREAM: begin
          r_t <= r_t + 1'b1;
          if (r_t == c_t_last) begin
            r_state <= DONE;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_ld_ready <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          r_t        <= '0;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_ld_ready <= 1'b1;
          r_we       <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign ld_ready = r_ld_ready;
  assign we       = r_we;

  // --------------------------------------------------------------------------
  // Skew lanes. A lane i walks along row i of A; B lane j walks down
  // column j of B, so the column is gathered from the row-major buffer first.
  // r_we doubles as the lane enable: operands are zero outside STREAM.
  // --------------------------------------------------------------------------
  generate
    for (genvar g_i = 0; g_i < N; g_i++) begin : g_lane
      logic [DATA_WIDTH*N-1:0] w_b_col;

      for (genvar g_k = 0; g_k < N; g_k++) begin : g_col
        assign w_b_col[g_k*DATA_WIDTH +: DATA_WIDTH] =
          r_b[g_k][g_i*DATA_WIDTH +: DATA_WIDTH];
      end

      feeder_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .CNT_WIDTH  (CNT_WIDTH),
        .LANE       (g_i)
      ) u_a_lane (
        .slice (r_a[g_i]),
        .t     (r_t),
        .en    (r_we),
        .elem  (a_in[g_i*DATA_WIDTH +: DATA_WIDTH])
      );

      feeder_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .CNT_WIDTH  (CNT_WIDTH),
        .LANE       (g_i)
      ) u_b_lane (
        .slice (w_b_col),
        .t     (r_t),
        .en    (r_we),
        .elem  (b_in[g_i*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_array_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_array_feeder
// Purpose  : Directed self-checking bench for array_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_array_feeder;

  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_sel;
  logic [1:0]  ld_row;
  logic [31:0] ld_data;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        we;

  int checks   = 0;
  int failures = 0;

  array_feeder #(
    .DATA_WIDTH (8),
    .N          (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_sel   (ld_sel),
    .ld_row   (ld_row),
    .ld_data  (ld_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .a_in     (a_in),
    .b_in     (b_in),
    .we       (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one edge and settle away from it.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic load_row(input logic sel, input logic [1:0] row, input logic [31:0] data);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_row   = row;
    ld_data  = data;
    next_cycle();
    ld_valid = 1'b0;
  endtask

  // Leaves the bench in the t=0 cycle of the stream.
  task automatic pulse_start();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ld_valid = 1'($urandom_range(0, 1));
      ld_sel   = 1'($urandom_range(0, 1));
      ld_row   = 2'($urandom_range(0, 3));
      ld_data  = $urandom;
      start    = 1'($urandom_range(0, 1));
      next_cycle();
      checks++;
      if ({busy, done, we, ld_ready, a_in, b_in} !== {4'b0001, 64'h0}) begin
        failures++;
        $display("FAIL reset_state c=%0d got busy/done/we/rdy=%b%b%b%b a=%h b=%h exp 0001 0 0",
                 c, busy, done, we, ld_ready, a_in, b_in);
      end
    end
    ld_valid = 1'b0;
    start    = 1'b0;
    ld_data  = '0;
    rst_n    = 1'b1;
    next_cycle();
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({we, a_in, b_in} !== {1'b1, 64'h0}) begin
        failures++;
        $display("FAIL empty_stream t=%0d got we=%b a=%h b=%h exp we=1 a=0 b=0", c, we, a_in, b_in);
      end
      next_cycle();
    end
    checks++;
    if ({done, we} !== 2'b10) begin
      failures++;
      $display("FAIL empty_done got done=%b we=%b exp done=1 we=0", done, we);
    end
    next_cycle();
  endtask

  task automatic test_skew();
    logic [31:0] ra [10];
    logic [31:0] rb [10];
    logic        rwe [10];
    for (int i = 0; i < 4; i++) begin
      load_row(1'b0, 2'(i), {8'(16*i+4), 8'(16*i+3), 8'(16*i+2), 8'(16*i+1)});
      load_row(1'b1, 2'(i), {8'(16*i+3+65), 8'(16*i+2+65), 8'(16*i+1+65), 8'(16*i+65)});
    end
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      ra[c]  = a_in;
      rb[c]  = b_in;
      rwe[c] = we;
      next_cycle();
    end
    checks++;
    if ({done, we, busy, ld_ready} !== 4'b1010) begin
      failures++;
      $display("FAIL skew_done_state got done/we/busy/rdy=%b%b%b%b exp 1010", done, we, busy, ld_ready);
    end
    next_cycle();
    checks++;
    if ({done, we, busy, ld_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL skew_idle_state got done/we/busy/rdy=%b%b%b%b exp 0001", done, we, busy, ld_ready);
    end
    checks++;
    if ({ra[0], rb[0]} !== {32'h00000001, 32'h00000041}) begin
      failures++;
      $display("FAIL skew_t0 got a=%h b=%h exp a=00000001 b=00000041", ra[0], rb[0]);
    end
    checks++;
    if ({ra[3], rb[3]} !== {32'h31221304, 32'h44536271}) begin
      failures++;
      $display("FAIL skew_t3 got a=%h b=%h exp a=31221304 b=44536271", ra[3], rb[3]);
    end
    checks++;
    if ({ra[6], rb[6]} !== {32'h34000000, 32'h74000000}) begin
      failures++;
      $display("FAIL skew_t6 got a=%h b=%h exp a=34000000 b=74000000", ra[6], rb[6]);
    end
    for (int c = 7; c < 10; c++) begin
      checks++;
      if ({ra[c], rb[c]} !== 64'h0) begin
        failures++;
        $display("FAIL skew_pad t=%0d got a=%h b=%h exp 0", c, ra[c], rb[c]);
      end
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (rwe[c] !== 1'b1) begin
        failures++;
        $display("FAIL skew_we t=%0d got %b exp 1", c, rwe[c]);
      end
    end
  endtask

  // Load attempt and start during STREAM: both ignored.
  task automatic test_protocol();
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_row   = 2'd0;
        ld_data  = 32'hFFFFFFFF;
        start    = 1'b1;
        checks++;
        if (ld_ready !== 1'b0) begin
          failures++;
          $display("FAIL proto_ready_stream got %b exp 0", ld_ready);
        end
      end
      if (c == 4) begin
        ld_valid = 1'b0;
        start    = 1'b0;
      end
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL proto_early_done t=%0d got %b exp 0", c, done);
      end
      next_cycle();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL proto_done_time got %b exp 1", done);
    end
    next_cycle();
    next_cycle();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL proto_start_not_queued got busy=%b exp 0", busy);
    end
    pulse_start();
    checks++;
    if (a_in !== 32'h00000001) begin
      failures++;
      $display("FAIL proto_buffer_kept_t0 got %h exp 00000001", a_in);
    end
    next_cycle();
    checks++;
    if (a_in !== 32'h00001102) begin
      failures++;
      $display("FAIL proto_buffer_kept_t1 got %h exp 00001102", a_in);
    end
    wait_cycles(10);
  endtask

  task automatic test_back_to_back();
    pulse_start();
    wait_cycles(10);
    start = 1'b1;
    next_cycle();
    checks++;
    if ({busy, we} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_ignored_in_done got busy=%b we=%b exp 00", busy, we);
    end
    next_cycle();
    start = 1'b0;
    checks++;
    if ({busy, we} !== 2'b11) begin
      failures++;
      $display("FAIL b2b_accepted got busy=%b we=%b exp 11", busy, we);
    end
    wait_cycles(11);
    checks++;
    if ({ld_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_return_idle got rdy=%b busy=%b exp 10", ld_ready, busy);
    end
  endtask

  task automatic test_same_cycle();
    ld_valid = 1'b1;
    ld_sel   = 1'b0;
    ld_row   = 2'd2;
    ld_data  = 32'h7F7F7F7F;
    start    = 1'b1;
    next_cycle();
    ld_valid = 1'b0;
    start    = 1'b0;
    wait_cycles(2);
    checks++;
    if ({a_in, b_in} !== {32'h007F1203, 32'h00435261}) begin
      failures++;
      $display("FAIL same_cycle_t2 got a=%h b=%h exp a=007F1203 b=00435261", a_in, b_in);
    end
    wait_cycles(9);
  endtask

  task automatic test_mid_reset();
    logic [31:0] exp_b [10];
    exp_b = '{32'h0, 32'h00000001, 32'h00000200, 32'h00030000, 32'h04000000,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    pulse_start();
    wait_cycles(5);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, we, ld_ready, a_in, b_in} !== {4'b0001, 64'h0}) begin
      failures++;
      $display("FAIL midreset_async got busy/done/we/rdy=%b%b%b%b a=%h b=%h exp 0001 0 0",
               busy, done, we, ld_ready, a_in, b_in);
    end
    next_cycle();
    rst_n = 1'b1;
    checks++;
    if ({busy, done, we, ld_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL midreset_held got busy/done/we/rdy=%b%b%b%b exp 0001", busy, done, we, ld_ready);
    end
    next_cycle();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL midreset_no_done got busy=%b done=%b exp 00", busy, done);
    end
    load_row(1'b1, 2'd1, 32'h04030201);
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({we, a_in, b_in} !== {1'b1, 32'h0, exp_b[c]}) begin
        failures++;
        $display("FAIL midreset_new_data t=%0d got we=%b a=%h b=%h exp we=1 a=0 b=%h",
                 c, we, a_in, b_in, exp_b[c]);
      end
      next_cycle();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL midreset_final_done got %b exp 1", done);
    end
    next_cycle();
  endtask

  initial begin
    rst_n    = 1'b0;
    ld_valid = 1'b0;
    ld_sel   = 1'b0;
    ld_row   = 2'd0;
    ld_data  = '0;
    start    = 1'b0;
    test_reset();
    test_skew();
    test_protocol();
    test_back_to_back();
    test_same_cycle();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
